// File: rtl/execute.sv
// Execute stage: single-cycle add/address/branch results and a multi-cycle
// unsigned shift-add multiplier producing {hi,lo}.
//
// Handshake: an instruction is taken on a rising edge where valid_i=1, reset=1
// and the stage is not multiplying (busy=0). While busy=1 the upstream stage
// holds its fields and valid_i is ignored. valid_o is a one-cycle pulse per
// completed non-bubble instruction; reg_wr_en and mem_rd pulse with it.
module execute #(
  parameter int MUL_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] sign_e_i,
  input  logic [4:0]  target_i,
  input  logic [4:0]  dest_i,
  output logic        busy,
  output logic        valid_o,
  output logic [31:0] alu_out,
  output logic [4:0]  wr_reg,
  output logic        reg_wr_en,
  output logic        mem_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  o_dbg_state
);

  localparam int        N      = 32 / MUL_STEP;
  localparam logic [5:0] N_LAST = 6'(N - 1);

  localparam logic [5:0] OP_ADDU = 6'd1;
  localparam logic [5:0] OP_BEQ  = 6'd2;
  localparam logic [5:0] OP_LW   = 6'd3;
  localparam logic [5:0] OP_MULT = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_J    = 6'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [63:0] w_acc_next;

  assign o_dbg_state = r_state;

  // One multiply step: add the shifted multiplicand for each retired multiplier bit.
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (r_mplier[k]) begin
        w_acc_next = w_acc_next + (r_mcand << k);
      end
    end
  end

  // Control FSM, operand/accumulator registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      busy      <= 1'b0;
      valid_o   <= 1'b0;
      reg_wr_en <= 1'b0;
      mem_rd    <= 1'b0;
      alu_out   <= '0;
      wr_reg    <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      valid_o   <= 1'b0;
      reg_wr_en <= 1'b0;
      mem_rd    <= 1'b0;
      case (r_state)
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          if (r_cnt == N_LAST) begin
            // Product becomes visible only here; partial sums stay internal.
            r_state  <= S_DONE;
            {hi, lo} <= w_acc_next;
            busy     <= 1'b0;
            valid_o  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
          // IDLE and DONE both accept; without a mult the stage returns to IDLE.
          r_state <= S_IDLE;
          if (valid_i) begin
            case (opcode_i)
              OP_ADDU: begin
                alu_out   <= a_i + b_i;
                wr_reg    <= dest_i;
                reg_wr_en <= 1'b1;
                valid_o   <= 1'b1;
              end
              OP_ADDI: begin
                alu_out   <= a_i + sign_e_i;
                wr_reg    <= target_i;
                reg_wr_en <= 1'b1;
                valid_o   <= 1'b1;
              end
              OP_LW: begin
                alu_out   <= a_i + sign_e_i;
                wr_reg    <= target_i;
                reg_wr_en <= 1'b1;
                mem_rd    <= 1'b1;
                valid_o   <= 1'b1;
              end
              OP_BEQ, OP_J: begin
                // Branch/jump already resolved upstream; only report completion.
                alu_out <= '0;
                valid_o <= 1'b1;
              end
              OP_MULT: begin
                r_mcand  <= {32'd0, a_i};
                r_mplier <= b_i;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_state  <= S_MUL;
                busy     <= 1'b1;
              end
              default: begin
                // Bubble: nothing completes and all results hold.
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
